// File: rtl/wb_sram_arbiter.sv
// Two-master round-robin Wishbone arbiter for the shared SRAM/flash bus.
// The grant is held for the whole CYC period; a watchdog aborts unanswered beats.
module wb_sram_arbiter #(
    parameter int unsigned ADDR_WIDTH     = 24,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TIMEOUT_WIDTH  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  wbs0_cyc_i,
    input  logic                  wbs0_stb_i,
    input  logic                  wbs0_we_i,
    input  logic [ADDR_WIDTH-1:0] wbs0_adr_i,
    input  logic [7:0]            wbs0_dat_i,
    input  logic [2:0]            wbs0_cti_i,
    input  logic [1:0]            wbs0_bte_i,
    output logic                  wbs0_ack_o,
    output logic                  wbs0_err_o,
    output logic                  wbs0_rty_o,
    output logic [7:0]            wbs0_dat_o,
    input  logic                  wbs1_cyc_i,
    input  logic                  wbs1_stb_i,
    input  logic                  wbs1_we_i,
    input  logic [ADDR_WIDTH-1:0] wbs1_adr_i,
    input  logic [7:0]            wbs1_dat_i,
    input  logic [2:0]            wbs1_cti_i,
    input  logic [1:0]            wbs1_bte_i,
    output logic                  wbs1_ack_o,
    output logic                  wbs1_err_o,
    output logic                  wbs1_rty_o,
    output logic [7:0]            wbs1_dat_o,
    output logic                  wbm_cyc_o,
    output logic                  wbm_stb_o,
    output logic                  wbm_we_o,
    output logic [ADDR_WIDTH-1:0] wbm_adr_o,
    output logic [7:0]            wbm_dat_o,
    output logic [2:0]            wbm_cti_o,
    output logic [1:0]            wbm_bte_o,
    input  logic                  wbm_ack_i,
    input  logic                  wbm_err_i,
    input  logic                  wbm_rty_i,
    input  logic [7:0]            wbm_dat_i,
    output logic                  timeout_o,
    output logic [1:0]            grant_o
);

    typedef enum logic [2:0] {IDLE, GRANT0, GRANT1, ABORT0, ABORT1} state_e;

    localparam bit                       WDOG_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [TIMEOUT_WIDTH-1:0] WDOG_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_e                   state_q, state_d;
    logic                     last_q, last_d;
    logic [TIMEOUT_WIDTH-1:0] wdog_q, wdog_d;

    logic                     sel1;
    logic                     own_cyc, own_stb, own_resp;

    // Round-robin pick: on a tie the requester that was not granted last wins.
    function automatic state_e arbitrate(input logic r0, input logic r1, input logic lst);
        if (r0 && r1) return lst ? GRANT0 : GRANT1;
        if (r0)       return GRANT0;
        if (r1)       return GRANT1;
        return IDLE;
    endfunction

    assign sel1     = (state_q == GRANT1) || (state_q == ABORT1);
    assign own_cyc  = sel1 ? wbs1_cyc_i : wbs0_cyc_i;
    assign own_stb  = sel1 ? wbs1_stb_i : wbs0_stb_i;
    assign own_resp = wbm_ack_i | wbm_err_i | wbm_rty_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            wdog_q  <= wdog_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        wdog_d     = '0;
        wbm_cyc_o  = 1'b0;
        wbm_stb_o  = 1'b0;
        wbm_we_o   = 1'b0;
        wbm_adr_o  = '0;
        wbm_dat_o  = '0;
        wbm_cti_o  = '0;
        wbm_bte_o  = '0;
        wbs0_ack_o = 1'b0;
        wbs0_err_o = 1'b0;
        wbs0_rty_o = 1'b0;
        wbs1_ack_o = 1'b0;
        wbs1_err_o = 1'b0;
        wbs1_rty_o = 1'b0;
        wbs0_dat_o = wbm_dat_i;
        wbs1_dat_o = wbm_dat_i;
        timeout_o  = 1'b0;
        grant_o    = 2'b00;

        case (state_q)
            IDLE: state_d = arbitrate(wbs0_cyc_i, wbs1_cyc_i, last_q);

            GRANT0, GRANT1: begin
                grant_o = sel1 ? 2'b10 : 2'b01;
                if (sel1) begin
                    wbm_cyc_o  = wbs1_cyc_i;
                    wbm_stb_o  = wbs1_stb_i;
                    wbm_we_o   = wbs1_we_i;
                    wbm_adr_o  = wbs1_adr_i;
                    wbm_dat_o  = wbs1_dat_i;
                    wbm_cti_o  = wbs1_cti_i;
                    wbm_bte_o  = wbs1_bte_i;
                    wbs1_ack_o = wbm_ack_i;
                    wbs1_err_o = wbm_err_i;
                    wbs1_rty_o = wbm_rty_i;
                end else begin
                    wbm_cyc_o  = wbs0_cyc_i;
                    wbm_stb_o  = wbs0_stb_i;
                    wbm_we_o   = wbs0_we_i;
                    wbm_adr_o  = wbs0_adr_i;
                    wbm_dat_o  = wbs0_dat_i;
                    wbm_cti_o  = wbs0_cti_i;
                    wbm_bte_o  = wbs0_bte_i;
                    wbs0_ack_o = wbm_ack_i;
                    wbs0_err_o = wbm_err_i;
                    wbs0_rty_o = wbm_rty_i;
                end

                // A response on the firing cycle wins, so the watchdog only looks at silent beats.
                if (!own_cyc) begin
                    state_d = arbitrate(wbs0_cyc_i, wbs1_cyc_i, last_q);
                end else if (WDOG_EN && own_stb && !own_resp) begin
                    if (wdog_q == WDOG_LAST) begin
                        timeout_o = 1'b1;
                        if (sel1) wbs1_err_o = 1'b1;
                        else      wbs0_err_o = 1'b1;
                        state_d = sel1 ? ABORT1 : ABORT0;
                    end else begin
                        wdog_d = wdog_q + TIMEOUT_WIDTH'(1);
                    end
                end
            end

            ABORT0, ABORT1: begin
                if (!own_cyc) state_d = arbitrate(wbs0_cyc_i, wbs1_cyc_i, last_q);
            end

            default: state_d = IDLE;
        endcase

        if (state_d == GRANT0) last_d = 1'b0;
        if (state_d == GRANT1) last_d = 1'b1;
    end

endmodule
